// File: rtl/pdm_modulator_if.sv
`default_nettype none
// ============================================================================
// Module      : pdm_modulator_if
// Description : Sample-input and bitstream-output bundle of the PCM-to-PDM
//               transmitter. The master side pushes PCM samples and observes
//               the PDM stream and status pulses; the slave side is the
//               modulator itself.
// Revision    : 1.0 - initial release
// ============================================================================
interface pdm_modulator_if;
  logic        Push;
  logic [15:0] Din;
  logic        Full;
  logic        BitOut;
  logic        FILTER;
  logic        Overflow;
  logic        Underrun;

  modport master (
    output Push,
    output Din,
    input  Full,
    input  BitOut,
    input  FILTER,
    input  Overflow,
    input  Underrun
  );

  modport slave (
    input  Push,
    input  Din,
    output Full,
    output BitOut,
    output FILTER,
    output Overflow,
    output Underrun
  );
endinterface
`default_nettype wire

// File: rtl/pdm_modulator.sv
`default_nettype none
// ============================================================================
// Module      : pdm_modulator
// Description : PCM-to-PDM transmitter. Signed 16-bit samples are queued in a
//               small FIFO and each one is held for OSR clocks while a
//               sigma-delta loop emits one PDM bit per clock. FILTER marks the
//               last bit of every frame for the decimating receiver.
//               Build option PDM_ORDER2_EN selects a second-order loop; when
//               undefined only the first-order integrator exists.
// Revision    : 1.0 - initial release
// ============================================================================
module pdm_modulator #(
  parameter int OSR        = 256,
  parameter int FIFO_DEPTH = 4,
  parameter int ACC_W      = 24
) (
  input  wire logic      Clock,
  input  wire logic      Reset,
  pdm_modulator_if.slave bus
);

  localparam int c_cnt_w  = $clog2(OSR);
  localparam int c_ptr_w  = $clog2(FIFO_DEPTH);
  localparam int c_fcnt_w = c_ptr_w + 1;
  // Two guard bits cover acc + x - fb before saturation.
  localparam int c_v_w    = ACC_W + 2;

  localparam logic [c_cnt_w-1:0]         c_last_bit   = c_cnt_w'(OSR - 1);
  localparam logic [c_fcnt_w-1:0]        c_depth      = c_fcnt_w'(FIFO_DEPTH);
  localparam logic signed [c_v_w-1:0]    c_sat_max    = {3'b000, {(ACC_W-1){1'b1}}};
  localparam logic signed [c_v_w-1:0]    c_sat_min    = -c_sat_max;
  localparam logic signed [c_v_w-1:0]    c_full_scale = c_v_w'(32768);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  state_t                     r_state;
  state_t                     w_state_next;

  logic [c_cnt_w-1:0]         r_bit_cnt;
  logic                       w_wrap;

  logic [15:0]                r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0]         r_wr_ptr;
  logic [c_ptr_w-1:0]         r_rd_ptr;
  logic [c_fcnt_w-1:0]        r_count;
  logic [c_fcnt_w-1:0]        w_count_next;
  logic                       r_full;
  logic                       w_push_ok;
  logic                       w_not_empty;
  logic                       w_pop;
  logic                       w_underrun;

  logic signed [15:0]         r_sample;
  logic signed [ACC_W-1:0]    r_acc1;
  logic signed [ACC_W-1:0]    w_acc1_next;
  logic signed [c_v_w-1:0]    w_x;
  logic signed [c_v_w-1:0]    w_fb;
  logic signed [c_v_w-1:0]    w_v1;
  logic                       w_bit_next;
  logic                       r_bit;
  logic                       r_overflow;
  logic                       r_underrun;

  // Clamp a guarded sum back into the symmetric integrator range.
  function automatic logic signed [ACC_W-1:0] f_sat(input logic signed [c_v_w-1:0] v);
    if (v > c_sat_max) begin
      return c_sat_max[ACC_W-1:0];
    end else if (v < c_sat_min) begin
      return c_sat_min[ACC_W-1:0];
    end else begin
      return v[ACC_W-1:0];
    end
  endfunction

  assign w_wrap      = (r_bit_cnt == c_last_bit);
  assign w_push_ok   = bus.Push && !r_full;
  assign w_not_empty = (r_count != '0);

  // Free-running frame counter; never gated so the FILTER cadence is fixed.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_bit_cnt <= '0;
    end else begin
      r_bit_cnt <= r_bit_cnt + c_cnt_w'(1);
    end
  end

  // Occupancy after this cycle; Full is judged from the registered count only.
  always_comb begin
    w_count_next = r_count;
    case ({w_push_ok, w_pop})
      2'b10:   w_count_next = r_count + c_fcnt_w'(1);
      2'b01:   w_count_next = r_count - c_fcnt_w'(1);
      default: w_count_next = r_count;
    endcase
  end

  // Sample FIFO storage, pointers and registered Full flag.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
    end else begin
      if (w_push_ok) begin
        r_mem[r_wr_ptr] <= bus.Din;
        r_wr_ptr        <= r_wr_ptr + c_ptr_w'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      end
      r_count <= w_count_next;
      r_full  <= (w_count_next == c_depth);
    end
  end

  // FSM state register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Frame-boundary decisions: pop a waiting sample or fall back to silence.
  always_comb begin
    w_state_next = r_state;
    w_pop        = 1'b0;
    w_underrun   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_wrap && w_not_empty) begin
          w_pop        = 1'b1;
          w_state_next = S_RUN;
        end
      end
      S_RUN: begin
        if (w_wrap) begin
          if (w_not_empty) begin
            w_pop = 1'b1;
          end else begin
            w_underrun   = 1'b1;
            w_state_next = S_IDLE;
          end
        end
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Sample register changes only at frame boundaries; silence when nothing queued.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_sample <= '0;
    end else if (w_wrap) begin
      r_sample <= w_pop ? $signed(r_mem[r_rd_ptr]) : 16'sd0;
    end
  end

  assign w_x  = {{(c_v_w-16){r_sample[15]}}, r_sample};
  assign w_fb = r_bit ? c_full_scale : -c_full_scale;

  // First integrator: accumulate input minus the fed-back full-scale level.
  always_comb begin
    w_v1        = {{2{r_acc1[ACC_W-1]}}, r_acc1} + w_x - w_fb;
    w_acc1_next = f_sat(w_v1);
  end

  // First integrator register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc1 <= '0;
    end else begin
      r_acc1 <= w_acc1_next;
    end
  end

`ifdef PDM_ORDER2_EN
  logic signed [ACC_W-1:0] r_acc2;
  logic signed [ACC_W-1:0] w_acc2_next;
  logic signed [c_v_w-1:0] w_v2;

  // Second integrator fed by the updated first integrator; its sign is the bit.
  always_comb begin
    w_v2        = {{2{r_acc2[ACC_W-1]}}, r_acc2}
                + {{2{w_acc1_next[ACC_W-1]}}, w_acc1_next} - w_fb;
    w_acc2_next = f_sat(w_v2);
    w_bit_next  = !w_acc2_next[ACC_W-1];
  end

  // Second integrator register.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_acc2 <= '0;
    end else begin
      r_acc2 <= w_acc2_next;
    end
  end
`else
  // Quantiser on the unsaturated first-order sum.
  always_comb begin
    w_bit_next = !w_v1[c_v_w-1];
  end
`endif

  // Registered PDM bit and status pulses.
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_bit      <= 1'b0;
      r_overflow <= 1'b0;
      r_underrun <= 1'b0;
    end else begin
      r_bit      <= w_bit_next;
      r_overflow <= bus.Push && r_full;
      r_underrun <= w_underrun;
    end
  end

  assign bus.BitOut   = r_bit;
  assign bus.FILTER   = w_wrap;
  assign bus.Full     = r_full;
  assign bus.Overflow = r_overflow;
  assign bus.Underrun = r_underrun;

endmodule
`default_nettype wire
